// File: rtl/unified_mem_arbiter_if.sv
// Requester and RAM-side signals of the unified memory arbiter.
// master = requesters plus the RAM read-data source; slave = the arbiter itself.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              mem_req;
  logic [3:0]        mem_wen;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              dbg_req;
  logic [31:0]       dbg_addr;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;

  logic              ram_en;
  logic [3:0]        ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              busy;

  modport master (
    output if_req, if_addr, mem_req, mem_wen, mem_addr, mem_wdata,
           dbg_req, dbg_addr, ram_rdata,
    input  if_ack, if_rdata, mem_ack, mem_rdata, dbg_ack, dbg_rdata,
           ram_en, ram_wen, ram_addr, ram_wdata, busy
  );

  modport slave (
    input  if_req, if_addr, mem_req, mem_wen, mem_addr, mem_wdata,
           dbg_req, dbg_addr, ram_rdata,
    output if_ack, if_rdata, mem_ack, mem_rdata, dbg_ack, dbg_rdata,
           ram_en, ram_wen, ram_addr, ram_wdata, busy
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous-read RAM among IF, MEM and DBG requesters,
// one access in flight at a time, with a one-cycle ack to the winner.
module unified_mem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  unified_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {GNT_IF, GNT_MEM, GNT_DBG} grant_t;

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  state_t            state;
  grant_t            grant;
  grant_t            winner;
  logic              grant_read;
  logic              any_req;
  logic [CNT_W-1:0]  starve_cnt;
  logic [DATA_W-1:0] if_hold, mem_hold, dbg_hold;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2],  bus.if_addr[1:0],
                              bus.mem_addr[31:ADDR_W+2], bus.mem_addr[1:0],
                              bus.dbg_addr[31:ADDR_W+2], bus.dbg_addr[1:0]};

  // Starved DBG overrides the fixed MEM > IF > DBG order.
  always_comb begin
    any_req = bus.if_req | bus.mem_req | bus.dbg_req;
    winner  = GNT_DBG;
    if (bus.dbg_req && (starve_cnt == CNT_W'(STARVE_LIMIT))) winner = GNT_DBG;
    else if (bus.mem_req)                                    winner = GNT_MEM;
    else if (bus.if_req)                                     winner = GNT_IF;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      grant         <= GNT_IF;
      grant_read    <= 1'b0;
      starve_cnt    <= '0;
      bus.busy      <= 1'b0;
      bus.ram_en    <= 1'b0;
      bus.ram_wen   <= 4'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      bus.if_ack    <= 1'b0;
      bus.mem_ack   <= 1'b0;
      bus.dbg_ack   <= 1'b0;
      if_hold       <= '0;
      mem_hold      <= '0;
      dbg_hold      <= '0;
    end else begin
      bus.if_ack  <= 1'b0;
      bus.mem_ack <= 1'b0;
      bus.dbg_ack <= 1'b0;
      if (!bus.dbg_req) starve_cnt <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= ACCESS;
            bus.busy   <= 1'b1;
            bus.ram_en <= 1'b1;
            grant      <= winner;
            case (winner)
              GNT_MEM: begin
                bus.ram_addr  <= bus.mem_addr[ADDR_W+1:2];
                bus.ram_wen   <= bus.mem_wen;
                bus.ram_wdata <= bus.mem_wdata;
                grant_read    <= (bus.mem_wen == 4'b0);
              end
              GNT_IF: begin
                bus.ram_addr  <= bus.if_addr[ADDR_W+1:2];
                bus.ram_wen   <= 4'b0;
                bus.ram_wdata <= '0;
                grant_read    <= 1'b1;
              end
              default: begin
                bus.ram_addr  <= bus.dbg_addr[ADDR_W+1:2];
                bus.ram_wen   <= 4'b0;
                bus.ram_wdata <= '0;
                grant_read    <= 1'b1;
              end
            endcase
            if (bus.dbg_req)
              starve_cnt <= (winner == GNT_DBG) ? '0 : starve_cnt + CNT_W'(1);
          end
        end
        ACCESS: begin
          state       <= RESP;
          bus.ram_en  <= 1'b0;
          bus.ram_wen <= 4'b0;
          case (grant)
            GNT_MEM: bus.mem_ack <= 1'b1;
            GNT_IF:  bus.if_ack  <= 1'b1;
            default: bus.dbg_ack <= 1'b1;
          endcase
        end
        RESP: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          if (grant_read) begin
            case (grant)
              GNT_MEM: mem_hold <= bus.ram_rdata;
              GNT_IF:  if_hold  <= bus.ram_rdata;
              default: dbg_hold <= bus.ram_rdata;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The synchronous RAM delivers data during RESP, so the winner sees it
  // alongside its ack; the hold register keeps it from then on.
  assign bus.if_rdata  = (state == RESP && grant == GNT_IF  && grant_read) ? bus.ram_rdata : if_hold;
  assign bus.mem_rdata = (state == RESP && grant == GNT_MEM && grant_read) ? bus.ram_rdata : mem_hold;
  assign bus.dbg_rdata = (state == RESP && grant == GNT_DBG && grant_read) ? bus.ram_rdata : dbg_hold;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a transaction-level model predicts
// every cycle's outputs, plus literal expectations for key scenarios.
module tb_unified_mem_arbiter;
  localparam int ADDR_W       = 8;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int DEPTH        = 256;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  unified_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  unified_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] ram       [DEPTH];
  logic [31:0] model_mem [DEPTH];

  function automatic logic [31:0] init_val(int i);
    logic [31:0] v;
    v = {8'(i), 8'(i ^ 8'h5A), 8'(255 - i), 8'(i + 3)};
    if (i == 0) v = 32'hCAFE0000;
    if (i == 5) v = 32'h24010001;
    if (i == 8) v = 32'h11223344;
    return v;
  endfunction

  // Behavioural synchronous-read RAM.
  always @(posedge clk) begin
    if (bus.ram_en) begin
      bus.ram_rdata <= ram[bus.ram_addr];
      for (int b = 0; b < 4; b++)
        if (bus.ram_wen[b]) ram[bus.ram_addr][b*8 +: 8] <= bus.ram_wdata[b*8 +: 8];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Transaction model: each grant occupies three clock edges; the cycle after
  // the grant edge strobes the RAM, the following one acks.
  int          edge_count = 0;
  int          free_edge  = 0;
  int          star       = 0;
  bit          txn_valid  = 0;
  int          txn_start, txn_who;
  bit          txn_read;
  logic [3:0]  txn_wen;
  logic [31:0] txn_data;
  logic        exp_en, exp_busy;
  logic [3:0]  exp_wen;
  logic [31:0] exp_addr, exp_wdata;
  logic        exp_ack   [3];
  logic [31:0] held_rdata[3];

  always @(posedge clk) begin
    logic [31:0] a, wd;
    logic [3:0]  wen;
    int          who, word;
    edge_count++;
    for (int i = 0; i < 3; i++) exp_ack[i] = 1'b0;
    if (!resetn) begin
      txn_valid = 0;
      free_edge = edge_count + 1;
      star      = 0;
      for (int i = 0; i < 3; i++) held_rdata[i] = 32'h0;
      exp_en = 0; exp_busy = 0; exp_wen = 0; exp_addr = 0; exp_wdata = 0;
    end else begin
      if (!txn_valid && edge_count >= free_edge && (bus.if_req || bus.mem_req || bus.dbg_req)) begin
        if (bus.dbg_req && star == STARVE_LIMIT) who = 2;
        else if (bus.mem_req)                    who = 1;
        else if (bus.if_req)                     who = 0;
        else                                     who = 2;
        a   = (who == 1) ? bus.mem_addr : (who == 0) ? bus.if_addr : bus.dbg_addr;
        wen = (who == 1) ? bus.mem_wen : 4'b0;
        wd  = (who == 1) ? bus.mem_wdata : 32'h0;
        word = int'((a >> 2) % 32'(DEPTH));
        txn_data = model_mem[word];
        for (int b = 0; b < 4; b++)
          if (wen[b]) model_mem[word][b*8 +: 8] = wd[b*8 +: 8];
        txn_valid = 1; txn_start = edge_count; txn_who = who;
        txn_read  = (wen == 4'b0); txn_wen = wen;
        free_edge = edge_count + 3;
        exp_addr  = 32'(word); exp_wdata = wd;
        if (bus.dbg_req) star = (who == 2) ? 0 : star + 1;
      end
      if (!bus.dbg_req) star = 0;
      exp_busy = txn_valid;
      exp_en   = txn_valid && (edge_count == txn_start);
      exp_wen  = exp_en ? txn_wen : 4'b0;
      if (txn_valid && edge_count == txn_start + 1) begin
        exp_ack[txn_who] = 1'b1;
        if (txn_read) held_rdata[txn_who] = txn_data;
        txn_valid = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    checkOutput("ram_en",    32'(bus.ram_en),    32'(exp_en));
    checkOutput("ram_wen",   32'(bus.ram_wen),   32'(exp_wen));
    checkOutput("ram_addr",  32'(bus.ram_addr),  exp_addr);
    checkOutput("ram_wdata", bus.ram_wdata,      exp_wdata);
    checkOutput("busy",      32'(bus.busy),      32'(exp_busy));
    checkOutput("if_ack",    32'(bus.if_ack),    32'(exp_ack[0]));
    checkOutput("mem_ack",   32'(bus.mem_ack),   32'(exp_ack[1]));
    checkOutput("dbg_ack",   32'(bus.dbg_ack),   32'(exp_ack[2]));
    checkOutput("if_rdata",  bus.if_rdata,       held_rdata[0]);
    checkOutput("mem_rdata", bus.mem_rdata,      held_rdata[1]);
    checkOutput("dbg_rdata", bus.dbg_rdata,      held_rdata[2]);
  end

  // Raises the selected requests and drops each one as its ack is seen.
  task automatic applyStimulus(input logic r_if, input logic r_mem, input logic r_dbg,
                               input logic [31:0] ia, input logic [31:0] ma, input logic [31:0] da,
                               input logic [3:0] wen, input logic [31:0] wd,
                               output int first_who, output int n_if, output int n_mem, output int n_dbg);
    n_if = 0; n_mem = 0; n_dbg = 0; first_who = -1;
    @(negedge clk);
    bus.if_addr = ia; bus.mem_addr = ma; bus.dbg_addr = da;
    bus.mem_wen = wen; bus.mem_wdata = wd;
    bus.if_req = r_if; bus.mem_req = r_mem; bus.dbg_req = r_dbg;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.mem_ack) begin n_mem++; bus.mem_req = 1'b0; if (first_who < 0) first_who = 1; end
      if (bus.if_ack)  begin n_if++;  bus.if_req  = 1'b0; if (first_who < 0) first_who = 0; end
      if (bus.dbg_ack) begin n_dbg++; bus.dbg_req = 1'b0; if (first_who < 0) first_who = 2; end
      if (!(bus.if_req || bus.mem_req || bus.dbg_req)) break;
    end
    checkOutput("handshake_done", 32'({bus.if_req, bus.mem_req, bus.dbg_req}), 32'h0);
    bus.if_req = 1'b0; bus.mem_req = 1'b0; bus.dbg_req = 1'b0;
  endtask

  initial begin
    int first, n_if, n_mem, n_dbg, mem_before, dbg_seen;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]       = init_val(i);
      model_mem[i] = init_val(i);
    end
    bus.if_req = 1'b1; bus.mem_req = 1'b1; bus.dbg_req = 1'b1;
    bus.if_addr = 0; bus.mem_addr = 0; bus.dbg_addr = 0;
    bus.mem_wen = 4'b0; bus.mem_wdata = 0;

    repeat (2) @(negedge clk);
    checkOutput("reset_ram_en", 32'(bus.ram_en), 32'h0);
    checkOutput("reset_busy",   32'(bus.busy),   32'h0);
    checkOutput("reset_acks",   32'({bus.if_ack, bus.mem_ack, bus.dbg_ack}), 32'h0);
    resetn = 1'b1;
    bus.if_req = 1'b0; bus.mem_req = 1'b0; bus.dbg_req = 1'b0;
    @(negedge clk);

    applyStimulus(1, 0, 0, 32'h14, 0, 0, 4'b0, 0, first, n_if, n_mem, n_dbg);
    checkOutput("if_read_lit", bus.if_rdata, 32'h24010001);
    checkOutput("if_ack_count", 32'(n_if), 32'd1);

    applyStimulus(0, 1, 0, 0, 32'h20, 0, 4'b0010, 32'h0000AB00, first, n_if, n_mem, n_dbg);
    checkOutput("write_keeps_mem_rdata", bus.mem_rdata, 32'h0);
    applyStimulus(0, 1, 0, 0, 32'h20, 0, 4'b0000, 32'h0, first, n_if, n_mem, n_dbg);
    checkOutput("byte_write_lit", bus.mem_rdata, 32'h1122AB44);

    applyStimulus(1, 1, 0, 32'h14, 32'h20, 0, 4'b0, 0, first, n_if, n_mem, n_dbg);
    checkOutput("mem_before_if", 32'(first), 32'd1);
    checkOutput("dual_if_acks",  32'(n_if),  32'd1);
    checkOutput("dual_mem_acks", 32'(n_mem), 32'd1);

    applyStimulus(0, 0, 1, 0, 0, 32'h08, 4'b0, 0, first, n_if, n_mem, n_dbg);
    checkOutput("dbg_read_lit", bus.dbg_rdata, init_val(2));

    // IF and MEM never let go; DBG must still get through.
    @(negedge clk);
    bus.if_addr = 32'h14; bus.mem_addr = 32'h24; bus.mem_wen = 4'b0; bus.dbg_addr = 32'h0C;
    bus.if_req = 1'b1; bus.mem_req = 1'b1; bus.dbg_req = 1'b1;
    mem_before = 0; dbg_seen = 0;
    for (int c = 0; c < 40 && !dbg_seen; c++) begin
      @(negedge clk);
      if (bus.mem_ack) mem_before++;
      if (bus.dbg_ack) dbg_seen = 1;
    end
    bus.if_req = 1'b0; bus.mem_req = 1'b0; bus.dbg_req = 1'b0;
    checkOutput("starve_mem_grants", 32'(mem_before), 32'd4);
    checkOutput("starve_dbg_granted", 32'(dbg_seen), 32'd1);
    repeat (3) @(negedge clk);

    applyStimulus(1, 0, 0, 32'h400, 0, 0, 4'b0, 0, first, n_if, n_mem, n_dbg);
    checkOutput("wrap_lit", bus.if_rdata, 32'hCAFE0000);

    // Reset lands while the write is strobed: no ack, but the write sticks.
    @(negedge clk);
    bus.mem_addr = 32'h30; bus.mem_wen = 4'hF; bus.mem_wdata = 32'hDEADBEEF; bus.mem_req = 1'b1;
    @(negedge clk);
    checkOutput("abort_in_access", 32'(bus.ram_en), 32'h1);
    resetn = 1'b0; bus.mem_req = 1'b0;
    @(negedge clk);
    checkOutput("abort_no_ack", 32'(bus.mem_ack), 32'h0);
    checkOutput("abort_idle",   32'(bus.busy),    32'h0);
    resetn = 1'b1;
    @(negedge clk);
    applyStimulus(0, 0, 1, 0, 0, 32'h30, 4'b0, 0, first, n_if, n_mem, n_dbg);
    checkOutput("abort_write_kept", bus.dbg_rdata, 32'hDEADBEEF);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Arbitrates one single-port synchronous-read word RAM among three requesters:
- the instruction-fetch stage (IF),
- the load/store stage (MEM),
- the board display/debug reader (DBG).

It replaces separate instruction and data memories with one unified memory. It runs a small FSM, so exactly one RAM access is in flight at a time, and it returns read data with a one-cycle ack pulse to the winning requester.

Parameters:
ADDR_W, 8, RAM word-address width (RAM depth = 2^ADDR_W words)
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive grants to IF/MEM while dbg_req is pending before DBG is forced to win

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
if_req  in  1  IF read request, level, held until if_ack
if_addr  in  32  IF byte address
if_ack  out  1  one-cycle pulse, if_rdata valid
if_rdata  out  DATA_W  registered IF read data
mem_req  in  1  MEM request, level, held until mem_ack
mem_wen  in  4  byte write enables; 0 = read
mem_addr  in  32  MEM byte address
mem_wdata  in  DATA_W  MEM write data
mem_ack  out  1  one-cycle pulse, access complete
mem_rdata  out  DATA_W  registered MEM read data (reads only)
dbg_req  in  1  DBG read request, level, held until dbg_ack
dbg_addr  in  32  DBG byte address
dbg_ack  out  1  one-cycle pulse
dbg_rdata  out  DATA_W  registered DBG read data
ram_en  out  1  RAM access strobe
ram_wen  out  4  RAM byte write enables
ram_addr  out  ADDR_W  RAM word address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_en
busy  out  1  high in any state other than IDLE

Behaviour:
Reset (resetn=0 at a clk edge):
- state=IDLE; all acks 0; ram_en 0; ram_wen 0.
- ram_addr, ram_wdata, all *_rdata = 0; starve counter 0.
- Reset mid-transaction abandons it: no ack is issued, and a write already strobed stays in RAM.

FSM states IDLE, ACCESS, RESP, all driven by registered outputs:
- IDLE: if any req is high, latch the winner's id, word address (addr[ADDR_W+1:2]), wen and wdata; go to ACCESS. Otherwise stay in IDLE.
- ACCESS: ram_en=1, ram_wen=latched wen (always 0 for IF/DBG), ram_addr/ram_wdata from the latch. Go to RESP.
- RESP: ram_en=0, ram_wen=0. Winner's ack=1 for this single cycle. For a read, winner's rdata <= ram_rdata at the edge entering RESP, so it is valid together with the ack. Go to IDLE.

Timing and handshake:
- A req sampled high at edge k gives ACCESS in cycle k+1 and ack in cycle k+2. Minimum 3 cycles per access, including the IDLE slot.
- The requester drops req in the cycle after it sees ack. IDLE samples in that cycle, so no duplicate access occurs.
- Address, wen and wdata are sampled only in IDLE. Changes while the transaction is in flight are ignored.
- *_rdata holds its value until that requester's next read ack. A MEM write leaves mem_rdata unchanged.

Priority among requests sampled in IDLE:
- Default order: MEM > IF > DBG.
- Starve counter increments on every grant to IF or MEM while dbg_req=1. It resets to 0 on a DBG grant or when dbg_req=0.
- When counter == STARVE_LIMIT, DBG wins regardless of the other requests.

Address handling:
- Byte-address bits [1:0] are ignored.
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo the RAM size.

Test Plan:
- Reset: hold resetn=0 for 2 cycles with all reqs high -> all acks 0, ram_en 0, busy 0; the first ram_en appears 2 cycles after resetn rises.
- Single IF read: RAM[5]=0x24010001; if_req=1, if_addr=0x14 -> ram_en/ram_addr=5 in cycle k+1; if_ack=1 with if_rdata=0x24010001 in cycle k+2; busy high for exactly 2 cycles.
- MEM byte write then read: mem_wen=4'b0010, addr=0x20, wdata=0x0000AB00, then a read of 0x20 -> ram_wen=0010 in the write's ACCESS cycle; the read returns 0x..AB.. with the other bytes unchanged; mem_rdata is not updated by the write ack.
- Simultaneous IF+MEM requests -> MEM granted first and IF second; each gets exactly one ack pulse; exactly 2 ram_en pulses.
- Starvation: dbg_req held with IF and MEM continuously requesting, STARVE_LIMIT=4 -> DBG is granted on the 5th arbitration; its counter then resets.
- Wrap and reset-abort: if_addr=0x400 reads RAM[0]; resetn=0 asserted during ACCESS -> no ack, state IDLE the next cycle.
